// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request-unit and RAM-side signals of the memory arbiter
interface mem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic iREN, ihit, dREN, dWEN, dhit, ramREN, ramWEN, ram_ready;
  logic [ADDR_W-1:0] iaddr, daddr, ramaddr;
  logic [DATA_W-1:0] iload, dstore, dload, ramstore, ramload;
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
  );
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction/data requests onto a single-port RAM; MEM_ARBITER_PERF_EN adds hit counters
module mem_arbiter #(parameter int ADDR_W = 32, parameter int DATA_W = 32) (
  input logic clk,
  input logic RST,
  mem_arbiter_if.slave bus
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [31:0] icount,
  output logic [31:0] dcount
`endif
);
  typedef enum logic [2:0] {IDLE, IACC, DACC, IRESP, DRESP} state_t;
  state_t state, state_n;
  logic fair, fair_n, ihit_n, dhit_n, ren_n, wen_n, dreq;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] store_n, iload_n, dload_n;
  assign dreq = bus.dREN | bus.dWEN;
  // next state and next registered outputs; ramaddr/ramstore/ramWEN double as the holding registers
  always_comb begin
    state_n = state;
    fair_n = fair;
    ihit_n = 1'b0;
    dhit_n = 1'b0;
    ren_n = bus.ramREN;
    wen_n = bus.ramWEN;
    addr_n = bus.ramaddr;
    store_n = bus.ramstore;
    iload_n = bus.iload;
    dload_n = bus.dload;
    case (state)
      IDLE:
        if (dreq && !(fair && bus.iREN)) begin
          state_n = DACC;
          ren_n = !bus.dWEN;
          wen_n = bus.dWEN;
          addr_n = bus.daddr;
          store_n = bus.dstore;
        end else if (bus.iREN) begin
          state_n = IACC;
          ren_n = 1'b1;
          addr_n = bus.iaddr;
        end
      IACC:
        if (!bus.iREN) begin
          state_n = IDLE;
          ren_n = 1'b0;
        end else if (bus.ram_ready) begin
          state_n = IRESP;
          ren_n = 1'b0;
          ihit_n = 1'b1;
          iload_n = bus.ramload;
        end
      DACC:
        if (!dreq) begin
          state_n = IDLE;
          ren_n = 1'b0;
          wen_n = 1'b0;
        end else if (bus.ram_ready) begin
          state_n = DRESP;
          ren_n = 1'b0;
          wen_n = 1'b0;
          dhit_n = 1'b1;
          dload_n = bus.ramWEN ? bus.dload : bus.ramload;
        end
      IRESP: begin
        state_n = IDLE;
        fair_n = 1'b0;
      end
      DRESP: begin
        state_n = IDLE;
        fair_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // state and output registers
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      state <= IDLE;
      fair <= 1'b0;
      bus.ihit <= 1'b0;
      bus.dhit <= 1'b0;
      bus.ramREN <= 1'b0;
      bus.ramWEN <= 1'b0;
      bus.ramaddr <= '0;
      bus.ramstore <= '0;
      bus.iload <= '0;
      bus.dload <= '0;
    end else begin
      state <= state_n;
      fair <= fair_n;
      bus.ihit <= ihit_n;
      bus.dhit <= dhit_n;
      bus.ramREN <= ren_n;
      bus.ramWEN <= wen_n;
      bus.ramaddr <= addr_n;
      bus.ramstore <= store_n;
      bus.iload <= iload_n;
      bus.dload <= dload_n;
    end
`ifdef MEM_ARBITER_PERF_EN
  // hit counters advance in step with the hit pulses
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      icount <= '0;
      dcount <= '0;
    end else begin
      icount <= icount + {31'd0, ihit_n};
      dcount <= dcount + {31'd0, dhit_n};
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a RAM and requester model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic RST = 1'b1;
  logic init_ram = 1'b1;
  logic use_ram = 1'b0;
  logic [31:0] ramload_v = '0;
  logic [31:0] ram [16];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] icount, dcount;
  mem_arbiter dut (.clk(clk), .RST(RST), .bus(bus), .icount(icount), .dcount(dcount));
`else
  mem_arbiter dut (.clk(clk), .RST(RST), .bus(bus));
`endif
  assign bus.ramload = use_ram ? ram[bus.ramaddr[3:0]] : ramload_v;

  function automatic logic [31:0] init_word(int i);
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  always @(posedge clk)
    if (init_ram) for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
    else if (bus.ramWEN && bus.ram_ready) ram[bus.ramaddr[3:0]] <= bus.ramstore;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    init_ram = 1'b1;
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0; bus.ram_ready = 0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    repeat (2) tick;
    checks++;
    if ({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN});
    end
    checks++;
    if (bus.iload !== 32'h0 || bus.dload !== 32'h0) begin
      errors++; $display("FAIL reset_loads: got %h/%h expected 0/0", bus.iload, bus.dload);
    end
    checks++;
    if (bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0) begin
      errors++; $display("FAIL reset_ram_bus: got %h/%h expected 0/0", bus.ramaddr, bus.ramstore);
    end
    init_ram = 1'b0;
    RST = 1'b0;
    bus.ram_ready = 1'b1;
    tick;
    checks++;
    if (bus.ramREN !== 1'b0 || bus.ihit !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got ramREN=%b ihit=%b expected 0/0", bus.ramREN, bus.ihit);
    end
  endtask

  task automatic test_ifetch;
    bus.iaddr = 32'h4; bus.iREN = 1'b1; ramload_v = 32'h2001_0005; bus.ram_ready = 1'b1;
    tick;
    checks++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h4 || bus.ihit !== 1'b0) begin
      errors++; $display("FAIL ifetch_c1: got ramREN=%b addr=%h ihit=%b expected 1/4/0", bus.ramREN, bus.ramaddr, bus.ihit);
    end
    tick;
    checks++;
    if (bus.ihit !== 1'b1 || bus.iload !== 32'h2001_0005) begin
      errors++; $display("FAIL ifetch_hit: got ihit=%b iload=%h expected 1/20010005", bus.ihit, bus.iload);
    end
    checks++;
    if (bus.ramREN !== 1'b0) begin
      errors++; $display("FAIL ifetch_strobe_off: got %b expected 0", bus.ramREN);
    end
    bus.iREN = 1'b0;
    tick;
    checks++;
    if (bus.ihit !== 1'b0 || bus.ramREN !== 1'b0) begin
      errors++; $display("FAIL ifetch_single: got ihit=%b ramREN=%b expected 0/0", bus.ihit, bus.ramREN);
    end
    tick;
  endtask

  task automatic test_dwrite_wait;
    int wen = 0, ren = 0, hits = 0;
    bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'hDEAD_BEEF; bus.ram_ready = 1'b0;
    tick;
    for (int k = 1; k <= 7; k++) begin
      if (bus.ramWEN && bus.ramaddr == 32'h80 && bus.ramstore == 32'hDEAD_BEEF) wen++;
      if (bus.ramREN) ren++;
      if (bus.dhit) begin hits++; bus.dWEN = 1'b0; end
      bus.ram_ready = (k >= 4);
      tick;
    end
    checks++;
    if (wen != 4) begin errors++; $display("FAIL dwrite_strobe_cycles: got %0d expected 4", wen); end
    checks++;
    if (hits != 1) begin errors++; $display("FAIL dwrite_hits: got %0d expected 1", hits); end
    checks++;
    if (ren != 0) begin errors++; $display("FAIL dwrite_no_read: got %0d expected 0", ren); end
    checks++;
    if (bus.dload !== 32'h0) begin errors++; $display("FAIL dwrite_dload: got %h expected 0", bus.dload); end
    checks++;
    if (ram[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dwrite_ram: got %h expected deadbeef", ram[0]); end
  endtask

  task automatic test_fairness;
    bit seq[$];
    bit fair = 0, exp_d;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    bus.iREN = 1'b1; bus.dREN = 1'b1; bus.iaddr = 32'h10; bus.daddr = 32'h24; bus.ram_ready = 1'b1;
    for (int c = 0; c < 40 && seq.size() < 4; c++) begin
      tick;
      if (bus.ihit && bus.dhit) begin errors++; checks++; $display("FAIL fair_dual_hit: got both hits expected one"); end
      if (bus.dhit) seq.push_back(1'b1);
      if (bus.ihit) seq.push_back(1'b0);
    end
    bus.iREN = 1'b0; bus.dREN = 1'b0;
    checks++;
    if (seq.size() != 4) begin errors++; $display("FAIL fair_timeout: got %0d hits expected 4", seq.size()); end
    for (int k = 0; k < seq.size(); k++) begin
      exp_d = !fair;
      checks++;
      if (seq[k] !== exp_d) begin errors++; $display("FAIL fair_order[%0d]: got data=%b expected data=%b", k, seq[k], exp_d); end
      fair = exp_d;
    end
    repeat (2) tick;
  endtask

  task automatic test_abort;
    bus.iREN = 1'b1; bus.iaddr = 32'h30; bus.ram_ready = 1'b0;
    tick;
    checks++;
    if (bus.ramREN !== 1'b1) begin errors++; $display("FAIL abort_strobe: got %b expected 1", bus.ramREN); end
    tick;
    bus.iREN = 1'b0;
    tick;
    checks++;
    if (bus.ramREN !== 1'b0 || bus.ihit !== 1'b0) begin
      errors++; $display("FAIL abort_drop: got ramREN=%b ihit=%b expected 0/0", bus.ramREN, bus.ihit);
    end
    tick;
    checks++;
    if (bus.ihit !== 1'b0) begin errors++; $display("FAIL abort_nohit: got %b expected 0", bus.ihit); end
    bus.iREN = 1'b1; bus.iaddr = 32'h34; bus.ram_ready = 1'b1; ramload_v = 32'h55;
    tick;
    checks++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h34) begin
      errors++; $display("FAIL abort_regrant: got ramREN=%b addr=%h expected 1/34", bus.ramREN, bus.ramaddr);
    end
    tick;
    checks++;
    if (bus.ihit !== 1'b1 || bus.iload !== 32'h55) begin
      errors++; $display("FAIL abort_rehit: got ihit=%b iload=%h expected 1/55", bus.ihit, bus.iload);
    end
    bus.iREN = 1'b0;
    repeat (2) tick;
  endtask

  task automatic test_async_reset;
    bus.dREN = 1'b1; bus.daddr = 32'h44; bus.ram_ready = 1'b0;
    tick;
    checks++;
    if (bus.ramREN !== 1'b1) begin errors++; $display("FAIL areset_strobe: got %b expected 1", bus.ramREN); end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN} !== 4'b0 || bus.iload !== 32'h0 || bus.dload !== 32'h0
        || bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0) begin
      errors++; $display("FAIL areset_outputs: got flags=%b iload=%h dload=%h addr=%h store=%h expected all 0",
        {bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN}, bus.iload, bus.dload, bus.ramaddr, bus.ramstore);
    end
    bus.dREN = 1'b0;
    tick;
    RST = 1'b0;
    bus.iREN = 1'b1; bus.iaddr = 32'h8; bus.ram_ready = 1'b1; ramload_v = 32'h77;
    tick;
    checks++;
    if (bus.ihit !== 1'b0 || bus.ramREN !== 1'b1) begin
      errors++; $display("FAIL areset_c1: got ihit=%b ramREN=%b expected 0/1", bus.ihit, bus.ramREN);
    end
    tick;
    checks++;
    if (bus.ihit !== 1'b1 || bus.iload !== 32'h77) begin
      errors++; $display("FAIL areset_hit: got ihit=%b iload=%h expected 1/77", bus.ihit, bus.iload);
    end
    bus.iREN = 1'b0;
    repeat (2) tick;
  endtask

  task automatic test_random;
    logic [31:0] ref_mem [16];
    bit ip = 0, dp = 0, dw = 0, pi = 0, pd = 0, fair = 0, prev_str = 0, str, isd, exp_d;
    int nih = 0, ndh = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    ref_mem[0] = 32'hDEAD_BEEF;
    use_ram = 1'b1;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    for (int c = 0; c < 600; c++) begin
      tick;
      str = bus.ramREN | bus.ramWEN;
      checks++;
      if (bus.ramREN && bus.ramWEN) begin errors++; $display("FAIL rand_both_strobes: cycle %0d got 11 expected one-hot", c); end
      if (str && !prev_str) begin
        isd = bus.ramWEN || bus.ramaddr[3];
        exp_d = pd && !(pi && fair);
        checks++;
        if (isd !== exp_d || !(pi || pd)) begin
          errors++; $display("FAIL rand_grant: cycle %0d got data=%b expected data=%b (pend i=%b d=%b)", c, isd, exp_d, pi, pd);
        end
        checks++;
        if (bus.ramaddr !== (isd ? bus.daddr : bus.iaddr) || bus.ramWEN !== (isd && dw)
            || (isd && dw && bus.ramstore !== bus.dstore)) begin
          errors++; $display("FAIL rand_ram_bus: cycle %0d got addr=%h wen=%b store=%h", c, bus.ramaddr, bus.ramWEN, bus.ramstore);
        end
      end
      if (bus.ihit) begin
        checks++;
        if (!ip || bus.iload !== ref_mem[bus.iaddr[3:0]]) begin
          errors++; $display("FAIL rand_ihit: cycle %0d got %h expected %h pending=%b", c, bus.iload, ref_mem[bus.iaddr[3:0]], ip);
        end
        ip = 0; bus.iREN = 1'b0; fair = 0; nih++;
      end else if (!ip && $urandom_range(2) == 0) begin
        ip = 1; bus.iREN = 1'b1; bus.iaddr = 32'($urandom_range(7));
      end
      if (bus.dhit) begin
        checks++;
        if (!dp || (!dw && bus.dload !== ref_mem[bus.daddr[3:0]])) begin
          errors++; $display("FAIL rand_dhit: cycle %0d got %h expected %h pending=%b wr=%b", c, bus.dload, ref_mem[bus.daddr[3:0]], dp, dw);
        end
        if (dw) ref_mem[bus.daddr[3:0]] = bus.dstore;
        dp = 0; bus.dREN = 1'b0; bus.dWEN = 1'b0; fair = 1; ndh++;
      end else if (!dp && $urandom_range(2) == 0) begin
        dp = 1; dw = 1'($urandom_range(1));
        bus.daddr = 32'(8 + $urandom_range(7)); bus.dstore = $urandom;
        bus.dWEN = dw; bus.dREN = dw ? 1'($urandom_range(1)) : 1'b1;
      end
      bus.ram_ready = 1'($urandom_range(1));
      pi = ip; pd = dp; prev_str = str;
    end
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    repeat (2) tick;
    checks++;
    if (nih + ndh < 20) begin errors++; $display("FAIL rand_progress: got %0d hits expected at least 20", nih + ndh); end
`ifdef MEM_ARBITER_PERF_EN
    checks++;
    if (icount !== 32'(nih) || dcount !== 32'(ndh)) begin
      errors++; $display("FAIL perf_counts: got %0d/%0d expected %0d/%0d", icount, dcount, nih, ndh);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_ifetch;
    test_dwrite_wait;
    test_fairness;
    test_abort;
    test_async_reset;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Responder for the request unit's instruction and data memory requests.
- Arbitrates iREN/dREN/dWEN onto a single-port RAM and returns one-cycle ihit/dhit pulses with captured load data.
- Sits between the datapath/request unit and the RAM model.
- Captures request address and data at grant, so the RAM side stays stable for the whole access.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data word width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- RST  in  1  reset; one clock, asynchronous, active-high
- iREN  in  1  instruction read request (level, held until ihit)
- iaddr  in  ADDR_W  instruction address
- ihit  out  1  one-cycle pulse: iload valid
- iload  out  DATA_W  instruction word
- dREN  in  1  data read request (level, held until dhit)
- dWEN  in  1  data write request (level, held until dhit)
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  write data
- dhit  out  1  one-cycle pulse: data access complete, dload valid for reads
- dload  out  DATA_W  data read word
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data, valid when ram_ready=1
- ram_ready  in  1  RAM completes current access this cycle

## Operation
- FSM states: IDLE, IACC, DACC, IRESP, DRESP; all outputs registered.
- IDLE:
  - dREN|dWEN → DACC; else iREN → IACC.
  - Data has priority unless the fairness bit is set.
  - On grant, capture address, store data and direction (read/write) into holding registers.
- IACC/DACC:
  - Drive ramREN (or ramWEN for a data write), ramaddr and ramstore from the holding registers.
  - On ram_ready=1: capture ramload into iload/dload, deassert the RAM strobes, go to IRESP/DRESP.
- IRESP/DRESP:
  - ihit/dhit=1 for exactly this cycle; then → IDLE.
  - Set fairness bit after DRESP.
  - Clear fairness bit after IRESP.
- Fairness:
  - Fairness bit set in IDLE with both iREN and dREN|dWEN asserted → grant instruction.
  - Prevents back-to-back data grants from starving fetch.
- Abort: a request that drops while in IACC/DACC (iREN=0, or dREN=dWEN=0 respectively) deasserts the RAM strobes next cycle, returns to IDLE, and produces no hit.
- dREN and dWEN both asserted: treated as a write; dload unchanged.
- iload/dload hold their last value outside hit cycles.
- ramaddr/ramstore hold their last value when idle.

## Timing
- Reset values:
  - ihit, dhit, ramREN, ramWEN = 0
  - iload, dload, ramaddr, ramstore = 0
  - fairness bit = 0; state = IDLE
  - RST mid-access aborts immediately, with no hit.
- Latency, request seen in IDLE with RAM ready in its first access cycle:
  - Cycle 0: grant.
  - Cycle 1: strobe out; ram_ready sampled.
  - Cycle 2: hit.
  - Minimum 3 cycles request-to-hit; each extra ram_ready=0 cycle adds one.
- Handshake:
  - The requester deasserts on the edge where it samples the hit.
  - The arbiter is back in IDLE on that same edge, so a held request is never double-served.
- Strobes are never asserted in IDLE, IRESP or DRESP.
- ramREN and ramWEN are never both 1.
- ram_ready outside IACC/DACC is ignored.

## Configuration
- MEM_ARBITER_PERF_EN defined:
  - Adds outputs icount and dcount, 32-bit each, reset 0.
  - Each increments by 1 on every ihit/dhit, wrapping at 2^32.
- MEM_ARBITER_PERF_EN undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset then iREN=1, iaddr=0x0000_0004, ramload=0x2001_0005, ram_ready=1 always → ramREN high in cycle 1, ihit=1 with iload=0x2001_0005 in cycle 2, ramREN=0 in cycle 2.
- dWEN=1, daddr=0x80, dstore=0xDEAD_BEEF, ram_ready low for 3 cycles then high → ramWEN high for 4 cycles with ramaddr=0x80 and ramstore=0xDEAD_BEEF; dhit pulses once; dload unchanged.
- iREN and dREN held together from reset → grant order D, I, D, I; no two consecutive hits of the same type.
- iREN dropped in the second IACC cycle with ram_ready=0 → ramREN=0 next cycle, state IDLE, no ihit.
- Assert RST asynchronously mid-DACC → all outputs 0 immediately; after release, a new iREN is served in 3 cycles.
- With MEM_ARBITER_PERF_EN, 5 instruction fetches and 2 data loads → icount=5, dcount=2.
